// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain clock/data pull-low enables.
// Defining PS2_HOST_TX_RETRY_EN adds one automatic retry after a NACK or timeout (reported in status[3]).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic        busy,
  output logic        done,
  output logic [31:0] status
);

  localparam int SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

  logic [SYNC_N-1:0] clk_sync_q;
  logic [SYNC_N-1:0] data_sync_q;
  logic              clk_prev_q;
  logic              clk_s;
  logic              data_s;
  logic              fe_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [9:0]       frame_q, frame_d;
  logic             ack_ok_q, ack_ok_d;
  logic             error_q, error_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_s;
  logic             give_up_s;
`ifdef PS2_HOST_TX_RETRY_EN
  logic             retried_q, retried_d;
  logic             nack_q, nack_d;
  logic             nack_idle_s;
`endif

  // Input synchronizers plus previous synchronized clock for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= {SYNC_N{1'b1}};
      data_sync_q <= {SYNC_N{1'b1}};
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_N-2:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[SYNC_N-2:0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[SYNC_N-1];
    end
  end

  assign clk_s  = clk_sync_q[SYNC_N-1];
  assign data_s = data_sync_q[SYNC_N-1];
  assign fe_s   = clk_prev_q & ~clk_s;

  // State, counters, frame and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      bit_idx_q <= 4'd0;
      frame_q   <= 10'd0;
      ack_ok_q  <= 1'b0;
      error_q   <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retried_q <= 1'b0;
      nack_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      ack_ok_q  <= ack_ok_d;
      error_q   <= error_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retried_q <= retried_d;
      nack_q    <= nack_d;
`endif
    end
  end

  // Next-state logic; the timeout check wins over a falling edge in the same cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    ack_ok_d  = ack_ok_q;
    error_d   = error_q;
    give_up_s = 1'b0;
    timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`ifdef PS2_HOST_TX_RETRY_EN
    retried_d   = retried_q;
    nack_d      = nack_q;
    nack_idle_s = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (wr_en) begin
          frame_d   = {1'b1, odd_parity(wr_data), wr_data};
          ack_ok_d  = 1'b0;
          error_d   = 1'b0;
          cnt_d     = {CNT_W{1'b0}};
          bit_idx_d = 4'd0;
          state_d   = ST_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retried_d = 1'b0;
          nack_d    = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RTS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RTS: begin
        if (timeout_s) begin
          give_up_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fe_s && (bit_idx_q == 4'd10)) begin
            bit_idx_d = 4'd11;
            state_d   = ST_WAIT_IDLE;
            if (!data_s) begin
              ack_ok_d = 1'b1;
            end else begin
`ifdef PS2_HOST_TX_RETRY_EN
              nack_d = 1'b1;
`else
              error_d = 1'b1;
`endif
            end
          end else if (fe_s) begin
            bit_idx_d = bit_idx_q + 4'd1;
          end else begin
            bit_idx_d = bit_idx_q;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (timeout_s) begin
          give_up_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (clk_s && data_s) begin
`ifdef PS2_HOST_TX_RETRY_EN
            nack_idle_s = nack_q;
`endif
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef PS2_HOST_TX_RETRY_EN
    if ((give_up_s || nack_idle_s) && !retried_q) begin
      retried_d = 1'b1;
      nack_d    = 1'b0;
      ack_ok_d  = 1'b0;
      cnt_d     = {CNT_W{1'b0}};
      bit_idx_d = 4'd0;
      state_d   = ST_INHIBIT;
    end else if (give_up_s || nack_idle_s) begin
      nack_d    = 1'b0;
      error_d   = 1'b1;
      ack_ok_d  = 1'b0;
      state_d   = ST_DONE;
    end else begin
      nack_d    = nack_d;
    end
`else
    if (give_up_s) begin
      error_d  = 1'b1;
      ack_ok_d = 1'b0;
      state_d  = ST_DONE;
    end else begin
      error_d  = error_d;
    end
`endif
  end

  // Line enables and handshake outputs are computed from the next state so they come straight from flops
  always_comb begin
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    case (state_d)
      ST_INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = (cnt_d == CNT_W'(INHIBIT_CYCLES - 1));
      end
      ST_RTS: begin
        if (bit_idx_d == 4'd0) begin
          data_oe_d = 1'b1;
        end else if (bit_idx_d <= 4'd10) begin
          data_oe_d = ~frame_d[bit_idx_d - 4'd1];
        end else begin
          data_oe_d = 1'b0;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef PS2_HOST_TX_RETRY_EN
  assign status      = {28'd0, retried_q, error_q, ack_ok_q, busy_q};
`else
  assign status      = {29'd0, error_q, ack_ok_q, busy_q};
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with an open-drain bus and a clocking PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 2000;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int          NACK_TRIES  = 2;
  localparam logic [31:0] BAD_STATUS  = 32'hC;
  localparam int          TMO_EXPECT  = 2 * TMO + INH;
`else
  localparam int          NACK_TRIES  = 1;
  localparam logic [31:0] BAD_STATUS  = 32'h4;
  localparam int          TMO_EXPECT  = TMO;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        dev_clk_low;
  logic        dev_data_low;
  logic        ps2_clk_oe;
  logic        ps2_data_oe;
  logic        busy;
  logic        done;
  logic [31:0] status;
  wire         line_clk  = ~(ps2_clk_oe | dev_clk_low);
  wire         line_data = ~(ps2_data_oe | dev_data_low);

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [10:0] exp_frame_q[$];
  logic [31:0] exp_status_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .ps2_clk_in (line_clk),
    .ps2_data_in(line_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .status     (status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    frame_of = {1'b1, ~(^b), b, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  // Waits for the inhibit phase, returns its length and the cycle index where data_oe first rose.
  task automatic wait_release(output int hi, output int dat_at);
    int guard;
    guard  = 0;
    hi     = 0;
    dat_at = -1;
    while (ps2_clk_oe !== 1'b1 && guard < 200) begin tick(); guard++; end
    while (ps2_clk_oe === 1'b1 && hi < 200) begin
      if (ps2_data_oe === 1'b1 && dat_at < 0) dat_at = hi;
      tick();
      hi++;
    end
  endtask

  task automatic wait_not_busy(input int max, output int n);
    n = 0;
    while (busy !== 1'b0 && n < max) begin tick(); n++; end
  endtask

  // Device model: 40-cycle clock starting 10 cycles after release, samples on rising edges.
  task automatic dev_frame(input bit ack, input bit poke, output logic [10:0] cap);
    dev_data_low = 1'b0;
    repeat (10) tick();
    cap[0] = line_data;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      repeat (20) tick();
      dev_clk_low = 1'b0;
      if (k <= 10) cap[k] = line_data;
      if (k < 11) begin
        repeat (5) tick();
        if (k == 10 && ack) dev_data_low = 1'b1;
        if (k == 4 && poke) begin
          wr_data = 8'h00;
          wr_en   = 1'b1;
          tick();
          wr_en   = 1'b0;
        end else begin
          tick();
        end
        repeat (14) tick();
      end else begin
        repeat (5) tick();
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) tick();
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
    checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (status !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", status); end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_ack_ed();
    int hi, dat_at, n, d0;
    logic [10:0] cap, exp_f;
    logic [31:0] exp_s;
    d0 = done_cnt;
    exp_frame_q.push_back(frame_of(8'hED));
    exp_status_q.push_back(32'h2);
    host_write(8'hED);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ed_busy: got %b expected 1", busy); end
    wait_release(hi, dat_at);
    checks++; if (hi != INH) begin errors++; $display("FAIL ed_inhibit_len: got %0d expected %0d", hi, INH); end
    checks++; if (dat_at != INH - 1) begin errors++; $display("FAIL ed_start_at: got %0d expected %0d", dat_at, INH - 1); end
    checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL ed_rts_data: got %b expected 1", ps2_data_oe); end
    dev_frame(1'b1, 1'b0, cap);
    exp_f = exp_frame_q.pop_front();
    checks++; if (cap !== exp_f) begin errors++; $display("FAIL ed_frame: got %h expected %h", cap, exp_f); end
    wait_not_busy(100, n);
    checks++; if (n >= 100) begin errors++; $display("FAIL ed_finish: still busy after %0d cycles", n); end
    repeat (3) tick();
    exp_s = exp_status_q.pop_front();
    checks++; if (status !== exp_s) begin errors++; $display("FAIL ed_status: got %h expected %h", status, exp_s); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ed_done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_nack_f4();
    int hi, dat_at, n, d0;
    logic [10:0] cap, exp_f;
    logic [31:0] exp_s;
    d0 = done_cnt;
    for (int a = 0; a < NACK_TRIES; a++) exp_frame_q.push_back(frame_of(8'hF4));
    exp_status_q.push_back(BAD_STATUS);
    host_write(8'hF4);
    for (int a = 0; a < NACK_TRIES; a++) begin
      wait_release(hi, dat_at);
      if (a == 0) begin
        checks++; if (hi != INH) begin errors++; $display("FAIL f4_inhibit_len: got %0d expected %0d", hi, INH); end
      end
      dev_frame(1'b0, 1'b0, cap);
      exp_f = exp_frame_q.pop_front();
      checks++; if (cap !== exp_f) begin errors++; $display("FAIL f4_frame: attempt %0d got %h expected %h", a, cap, exp_f); end
    end
    wait_not_busy(100, n);
    checks++; if (n >= 100) begin errors++; $display("FAIL f4_finish: still busy after %0d cycles", n); end
    repeat (3) tick();
    exp_s = exp_status_q.pop_front();
    checks++; if (status !== exp_s) begin errors++; $display("FAIL f4_status: got %h expected %h", status, exp_s); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL f4_done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_timeout_ff();
    int hi, dat_at, n, d0;
    logic [31:0] exp_s;
    d0 = done_cnt;
    exp_status_q.push_back(BAD_STATUS);
    host_write(8'hFF);
    wait_release(hi, dat_at);
    checks++; if (hi != INH) begin errors++; $display("FAIL ff_inhibit_len: got %0d expected %0d", hi, INH); end
    n = 0;
    while (done !== 1'b1 && n < 6000) begin
      tick();
      n++;
      if (n == 1000) begin
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin
          errors++; $display("FAIL ff_rts_lines: got clk_oe=%b data_oe=%b expected 0/1", ps2_clk_oe, ps2_data_oe);
        end
      end
    end
    checks++;
    if (n < TMO_EXPECT - 1 || n > TMO_EXPECT + 1) begin
      errors++; $display("FAIL ff_timeout_len: got %0d cycles expected %0d", n, TMO_EXPECT);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL ff_released: got clk_oe=%b data_oe=%b expected 0/0", ps2_clk_oe, ps2_data_oe);
    end
    repeat (3) tick();
    exp_s = exp_status_q.pop_front();
    checks++; if (status !== exp_s) begin errors++; $display("FAIL ff_status: got %h expected %h", status, exp_s); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ff_done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_ignore_busy();
    int hi, dat_at, n, d0;
    logic [10:0] cap, exp_f;
    logic [31:0] exp_s;
    d0 = done_cnt;
    exp_frame_q.push_back(frame_of(8'hED));
    exp_status_q.push_back(32'h2);
    host_write(8'hED);
    wait_release(hi, dat_at);
    dev_frame(1'b1, 1'b1, cap);
    exp_f = exp_frame_q.pop_front();
    checks++; if (cap !== exp_f) begin errors++; $display("FAIL busy_frame: got %h expected %h", cap, exp_f); end
    wait_not_busy(100, n);
    repeat (40) tick();
    exp_s = exp_status_q.pop_front();
    checks++; if (status !== exp_s) begin errors++; $display("FAIL busy_status: got %h expected %h", status, exp_s); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_rts();
    int hi, dat_at, d0;
    d0 = done_cnt;
    host_write(8'hED);
    wait_release(hi, dat_at);
    repeat (5) tick();
    checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL rst_pre_data_oe: got %b expected 1", ps2_data_oe); end
    reset = 1'b0;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async: got clk_oe=%b data_oe=%b busy=%b expected 0/0/0", ps2_clk_oe, ps2_data_oe, busy);
    end
    tick();
    checks++; if (status !== 32'h0) begin errors++; $display("FAIL rst_status: got %h expected 0", status); end
    reset = 1'b1;
    repeat (5) tick();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL rst_done: got %0d pulses expected 0", done_cnt - d0); end
  endtask

`ifdef PS2_HOST_TX_RETRY_EN
  task automatic test_retry();
    int hi, dat_at, n, d0;
    logic [10:0] cap, exp_f;
    logic [31:0] exp_s;
    d0 = done_cnt;
    exp_frame_q.push_back(frame_of(8'hED));
    exp_frame_q.push_back(frame_of(8'hED));
    exp_status_q.push_back(32'hA);
    host_write(8'hED);
    for (int a = 0; a < 2; a++) begin
      wait_release(hi, dat_at);
      dev_frame(a == 1, 1'b0, cap);
      exp_f = exp_frame_q.pop_front();
      checks++; if (cap !== exp_f) begin errors++; $display("FAIL retry_frame: attempt %0d got %h expected %h", a, cap, exp_f); end
    end
    wait_not_busy(100, n);
    repeat (3) tick();
    exp_s = exp_status_q.pop_front();
    checks++; if (status !== exp_s) begin errors++; $display("FAIL retry_status: got %h expected %h", status, exp_s); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL retry_done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask
`endif

  task automatic test_scoreboard_drained();
    checks++;
    if (exp_frame_q.size() != 0 || exp_status_q.size() != 0) begin
      errors++; $display("FAIL sb_drained: got %0d frames %0d statuses left expected 0", exp_frame_q.size(), exp_status_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ack_ed();
    test_nack_f4();
    test_timeout_ff();
    test_ignore_busy();
    test_reset_mid_rts();
`ifdef PS2_HOST_TX_RETRY_EN
    test_retry();
`endif
    test_scoreboard_drained();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends command bytes (LED set 0xED, reset 0xFF, enable 0xF4, ...) from the ARM core to the keyboard.
- Complements the existing PS/2 receive path, which handles device-to-host traffic.
- Memory-mapped: the core writes a byte with STR (wr_en = address decode & MemWrite) and reads status with LDR through the read mux.
- Drives the shared open-drain ps2 clock/data lines via active-high pull-low enables.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the host holds ps2 clock low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: max clk cycles from request-to-send until ACK and bus idle (20 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flop stages on ps2_clk_in and ps2_data_in (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  one-cycle write strobe from address decode.
- wr_data  in  8  command byte, sampled when wr_en=1.
- ps2_clk_in  in  1  ps2 clock line level.
- ps2_data_in  in  1  ps2 data line level.
- ps2_clk_oe  out  1  1 = pull ps2 clock low; 0 = release.
- ps2_data_oe  out  1  1 = pull ps2 data low; 0 = release.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of transfer (success or failure).
- status  out  32  {29'b0, error, ack_ok, busy}, for the LDR mux.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; busy=0, done=0, ps2_clk_oe=0, ps2_data_oe=0.
  - ack_ok=0, error=0; all counters and the shift register cleared.
  - Reset mid-transfer releases both lines immediately.
- Inputs: pass through SYNC_STAGES synchronizer. A falling edge (fe) is the previous synchronized clock =1 and current =0, detected SYNC_STAGES+1 cycles after the pin falls.
- IDLE:
  - On wr_en: latch wr_data. Form frame {stop=1, parity=~^wr_data (odd), D7..D0}.
  - Clear ack_ok and error, set busy=1, go to INHIBIT next cycle.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. In the last cycle assert ps2_data_oe=1 (start bit 0), then go to RTS.
- RTS: ps2_clk_oe=0, ps2_data_oe=1. Timeout counter starts at 0 on entry. Each fe advances bit_idx (0..10), updated in the cycle after fe:
  - fe 1..8: ps2_data_oe = ~D[bit_idx-1], LSB first.
  - fe 9: ps2_data_oe = ~parity.
  - fe 10: ps2_data_oe=0 (stop bit, line released).
  - fe 11: sample synchronized data. 0 sets ack_ok=1; 1 sets error=1 (NACK). Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronized clock=1 and data=1 in the same cycle, then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in RTS or WAIT_IDLE:
  - release both lines, set error=1, ack_ok=0, go to DONE.
  - Timeout takes priority over a simultaneous fe.
- wr_en while busy=1 is ignored: frame unchanged, no flag.
- ack_ok and error hold until the next accepted write.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - On NACK or timeout, the block automatically restarts once from INHIBIT with the same latched byte. busy stays 1, no done pulse between attempts.
  - error is set only if the retry also fails; done pulses once at the final end.
  - status[3] = retried (1 if a retry occurred), cleared on the next accepted write.
- Undefined: no retry; status[3]=0.

Test Plan:
- Sim settings: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000. Device model clocks at 40-cycle period, starts 10 cycles after clock release, samples data on the rising edge.
- Reset: reset=0 mid-RTS -> next cycle ps2_clk_oe=0, ps2_data_oe=0, busy=0; status=0.
- Write 0xED: ps2_clk_oe high exactly 20 cycles. Device captures start=0, data 0xED LSB first (1,0,1,1,0,1,1,1), parity=1, stop=1. Device ACKs -> done pulses once, status=0x2.
- Write 0xF4: device captures data 0xF4, parity=0. Device drives data=1 at ACK edge -> done pulse, status=0x4 (error, ack_ok=0).
- Write 0xFF, device never clocks -> after 2000 cycles in RTS: lines released, done pulse, status=0x4.
- Second wr_en (0x00) during an active 0xED transfer -> ignored; device receives 0xED only; single done pulse.
- With PS2_HOST_TX_RETRY_EN: first attempt NACK, second ACK -> two frames of 0xED on the wire, one done pulse, status=0xA.
